vga_frame_writer: RTL and testbench
===================================

// Module: vga_frame_writer
// PURPOSE
// Producer side of the VGA frame memory: takes the 4-bit processed-pixel stream
// (valid/ready, start-of-frame marker) and turns it into raster-ordered writes
// on the packed write bus {data[23:20], address[19:0]} consumed by the VGA
// output path. Also fills the whole frame with a constant on request. Sits
// between the Sobel pipeline and the VGA controller; clock is the VGA clock domain.
// PARAMETERS
// H_RES      640    pixels per line
// V_RES      480    lines per frame
// CLEAR_VAL  4'h0   pixel value written by a clear sweep
// PORTS
// clock       in   1   single clock (VGA domain)
// reset       in   1   asynchronous, active-low
// start       in   1   1-cycle pulse: arm for one frame (ignored unless IDLE)
// clear       in   1   1-cycle pulse: fill frame with CLEAR_VAL (ignored unless IDLE)
// in_valid    in   1   in_pixel/in_sof valid
// in_ready    out  1   beat accepted when in_valid & in_ready
// in_pixel    in   4   pixel data
// in_sof      in   1   beat is pixel (0,0) of a frame
// write_reg   out  24  {pixel[3:0], address[19:0]}, registered
// write_en    out  1   write_reg valid this cycle (1-cycle strobe per write)
// busy        out  1   state != IDLE
// frame_done  out  1   1-cycle pulse, coincident with write of the last address
// sof_error   out  1   1-cycle pulse: in_sof seen mid-frame
// BEHAVIOUR
// - Reset: state IDLE; write_reg=0, write_en=0, in_ready=0, busy=0,
//   frame_done=0, sof_error=0; x, y, addr counters=0.
// - States: IDLE, SYNC, WRITE, CLEAR.
//   IDLE : in_ready=0. start -> SYNC; clear -> CLEAR; both same cycle -> CLEAR.
//   SYNC : in_ready=1; beats with in_sof=0 discarded (no write). Beat with
//          in_sof=1 -> written to address 0, go WRITE with next addr=1.
//   WRITE: in_ready=1; each accepted beat written to addr, then x/y/addr advance:
//          x wraps H_RES-1->0 with y+1; addr = y*H_RES+x kept incrementally
//          (addr+1, no multiplier). Beat at (H_RES-1,V_RES-1): frame_done
//          with its write, counters -> 0, state -> IDLE.
//   CLEAR: in_ready=0; one write per cycle of CLEAR_VAL, addr 0..H_RES*V_RES-1;
//          frame_done on last write, then IDLE. start/clear ignored while busy.
// - Latency: accepted beat at edge N -> write_en=1, write_reg valid after edge N
//   (cycle N+1), for exactly one cycle. No back-pressure from memory; in_valid
//   low -> write_en low, counters hold.
// - Mid-frame in_sof in WRITE (addr != 0): sof_error pulse; that beat is
//   written to address 0 and counters restart at 1 (resync, no drop).
// - write_reg holds last written value when write_en=0.
// - Address width 20 bits; H_RES*V_RES must be <= 2^20 (307200 default).
// - reset asserted mid-frame/mid-clear: immediate return to reset values;
//   a partially written frame is not completed.
// STRUCTURE
// - Shared package/header: state encodings, H_RES/V_RES defaults, ADDR_W=20,
//   PIX_W=4, write_reg field offsets (ADDR_LSB=0, DATA_LSB=20).
// - One natural sub-module: vga_raster_counter (x, y, linear addr with wrap
//   and last-pixel flag, enable + sync clear); FSM and output regs in top.
// TESTING
// - Reset then idle: write_en=0, write_reg=24'h0, in_ready=0 for 100 cycles.
// - start, stream 3 non-SOF beats then SOF frame 0..307199 with pixel=addr[3:0]
//   -> first 3 discarded; 307200 writes, write_reg={addr[3:0],addr}; frame_done
//   exactly with addr 20'h4AFFF; then IDLE, in_ready=0.
// - Random in_valid gaps (50%) during frame -> addresses strictly contiguous,
//   one write_en per accepted beat, no duplicates.
// - SOF injected at beat 1000 -> sof_error pulse, that beat at address 0,
//   following beat at address 1; frame_done after 307200 further-from-0 beats.
// - clear with CLEAR_VAL=4'h5 -> 307200 consecutive writes of 4'h5 at 0..4AFFF,
//   in_ready=0 throughout, start pulsed mid-sweep ignored.
// - reset pulsed at beat 5000 -> all outputs to reset values same cycle; new
//   start+SOF frame writes from address 0.

Source files
------------

// File: rtl/vga_frame_writer_pkg.sv
// Shared definitions for the VGA frame writer: state encoding, bus geometry
// and the packing of the {pixel, address} write word.
package vga_frame_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    WRITE,
    CLEAR
  } state_t;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int ADDR_W    = 20;
  localparam int PIX_W     = 4;
  localparam int ADDR_LSB  = 0;
  localparam int DATA_LSB  = 20;
  localparam int WRITE_W   = PIX_W + ADDR_W;

  function automatic logic [WRITE_W-1:0] pack_write(input logic [PIX_W-1:0]  pixel,
                                                    input logic [ADDR_W-1:0] addr);
    logic [WRITE_W-1:0] word;
    word = '0;
    word[DATA_LSB +: PIX_W] = pixel;
    word[ADDR_LSB +: ADDR_W] = addr;
    return word;
  endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// Raster position tracker: x/y with line wrap and a linear address kept
// incrementally alongside, plus a flag for the last pixel of the frame.
module vga_raster_counter
  import vga_frame_writer_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              restart,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           x_last;
  logic           y_last;

  assign x_last = (x == X_W'(H_RES - 1));
  assign y_last = (y == Y_W'(V_RES - 1));
  assign last   = x_last & y_last;

  // restart places the counter just past pixel 0 (a frame's SOF beat was just written there)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (restart) begin
      x    <= X_W'(1);
      y    <= '0;
      addr <= ADDR_W'(1);
    end else if (enable) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
      addr <= last ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/vga_frame_writer.sv
// Turns the processed-pixel stream into raster-ordered frame-memory writes,
// and can sweep the whole frame with a constant value.
module vga_frame_writer
  import vga_frame_writer_pkg::*;
#(
  parameter int               H_RES     = H_RES_DEF,
  parameter int               V_RES     = V_RES_DEF,
  parameter logic [PIX_W-1:0] CLEAR_VAL = 4'h0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic               in_sof,
  output logic [WRITE_W-1:0] write_reg,
  output logic               write_en,
  output logic               busy,
  output logic               frame_done,
  output logic               sof_error
);

  state_t             state, state_next;
  logic [WRITE_W-1:0] write_next;
  logic               write_en_next;
  logic               done_next;
  logic               error_next;
  logic               cnt_enable;
  logic               cnt_clear;
  logic               cnt_restart;
  logic [ADDR_W-1:0]  addr;
  logic               last;
  logic               accept;

  vga_raster_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_raster (
    .clock   (clock),
    .reset   (reset),
    .enable  (cnt_enable),
    .clear   (cnt_clear),
    .restart (cnt_restart),
    .addr    (addr),
    .last    (last)
  );

  assign in_ready = (state == SYNC) || (state == WRITE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      write_reg  <= '0;
      write_en   <= 1'b0;
      frame_done <= 1'b0;
      sof_error  <= 1'b0;
    end else begin
      state      <= state_next;
      write_reg  <= write_next;
      write_en   <= write_en_next;
      frame_done <= done_next;
      sof_error  <= error_next;
    end
  end

  // A SOF beat always lands at address 0; mid-frame it also flags a resync.
  always_comb begin
    state_next    = state;
    write_next    = write_reg;
    write_en_next = 1'b0;
    done_next     = 1'b0;
    error_next    = 1'b0;
    cnt_enable    = 1'b0;
    cnt_clear     = 1'b0;
    cnt_restart   = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
          cnt_clear  = 1'b1;
        end else if (start) begin
          state_next = SYNC;
          cnt_clear  = 1'b1;
        end
      end
      SYNC: begin
        if (accept && in_sof) begin
          write_next    = pack_write(in_pixel, '0);
          write_en_next = 1'b1;
          cnt_restart   = 1'b1;
          state_next    = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          write_en_next = 1'b1;
          if (in_sof && (addr != '0)) begin
            write_next  = pack_write(in_pixel, '0);
            error_next  = 1'b1;
            cnt_restart = 1'b1;
          end else begin
            write_next = pack_write(in_pixel, addr);
            if (last) begin
              done_next  = 1'b1;
              cnt_clear  = 1'b1;
              state_next = IDLE;
            end else begin
              cnt_enable = 1'b1;
            end
          end
        end
      end
      CLEAR: begin
        write_next    = pack_write(CLEAR_VAL, addr);
        write_en_next = 1'b1;
        if (last) begin
          done_next  = 1'b1;
          cnt_clear  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_frame_writer.sv
// Directed bench for vga_frame_writer on a reduced 8x4 raster so that whole
// frames, clears and resyncs fit in a short run.
module tb_vga_frame_writer;

  localparam int H = 8;
  localparam int V = 4;
  localparam int N = H * V;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_pixel;
  logic        in_sof;
  logic [23:0] write_reg;
  logic        write_en;
  logic        busy;
  logic        frame_done;
  logic        sof_error;

  int checks = 0;
  int errors = 0;

  vga_frame_writer #(
    .H_RES(H),
    .V_RES(V),
    .CLEAR_VAL(4'h5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .write_reg  (write_reg),
    .write_en   (write_en),
    .busy       (busy),
    .frame_done (frame_done),
    .sof_error  (sof_error)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_pixel = 4'h0;
    repeat (3) tick();
    checks++;
    if (write_en !== 1'b0 || write_reg !== 24'h0 || in_ready !== 1'b0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || sof_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got we=%b wr=%h rdy=%b busy=%b done=%b err=%b expected all 0",
               write_en, write_reg, in_ready, busy, frame_done, sof_error);
    end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (write_en !== 1'b0 || in_ready !== 1'b0 || write_reg !== 24'h0) begin
        errors++;
        $display("[TB] FAIL idle cycle %0d got we=%b rdy=%b wr=%h expected 0/0/000000",
                 i, write_en, in_ready, write_reg);
      end
    end
  endtask

  task automatic test_frame;
    logic [19:0] a20;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL armed got busy=%b rdy=%b expected 1/1", busy, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_pixel = 4'hE;
      tick();
      checks++;
      if (write_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL discard beat %0d got we=%b expected 0", i, write_en);
      end
    end
    for (int a = 0; a < N; a++) begin
      a20 = 20'(a);
      in_valid = 1'b1; in_sof = (a == 0); in_pixel = a20[3:0];
      tick();
      checks++;
      if (write_en !== 1'b1 || write_reg !== {a20[3:0], a20} || frame_done !== (a == N - 1)) begin
        errors++;
        $display("[TB] FAIL frame write %0d got we=%b wr=%h done=%b expected 1/%h/%b",
                 a, write_en, write_reg, frame_done, {a20[3:0], a20}, (a == N - 1));
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame end got busy=%b rdy=%b expected 0/0", busy, in_ready);
    end
    tick();
    checks++;
    if (write_en !== 1'b0 || write_reg !== {4'hF, 20'd31} || frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold after frame got we=%b wr=%h done=%b expected 0/f0001f/0",
               write_en, write_reg, frame_done);
    end
  endtask

  task automatic test_gaps;
    int          expect_addr;
    int          cycles;
    logic        v;
    logic [3:0]  pix;
    logic [19:0] a20;
    expect_addr = 0;
    cycles = 0;
    pulse_start();
    while (expect_addr < N && cycles < 1000) begin
      v = 1'($urandom_range(0, 1));
      a20 = 20'(expect_addr);
      pix = a20[3:0] ^ 4'h9;
      in_valid = v; in_sof = (expect_addr == 0); in_pixel = pix;
      tick();
      cycles++;
      checks++;
      if (v) begin
        if (write_en !== 1'b1 || write_reg !== {pix, a20} || frame_done !== (expect_addr == N - 1)) begin
          errors++;
          $display("[TB] FAIL gap write %0d got we=%b wr=%h done=%b expected 1/%h/%b",
                   expect_addr, write_en, write_reg, frame_done, {pix, a20}, (expect_addr == N - 1));
        end
        expect_addr++;
      end else if (write_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gap idle cycle %0d got we=%b expected 0", cycles, write_en);
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    checks++;
    if (expect_addr != N || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap frame end got writes=%0d busy=%b expected %0d/0", expect_addr, busy, N);
    end
  endtask

  task automatic test_sof_resync;
    logic [19:0] a20;
    pulse_start();
    for (int a = 0; a < 20; a++) begin
      a20 = 20'(a);
      in_valid = 1'b1; in_sof = (a == 0); in_pixel = a20[3:0];
      tick();
      checks++;
      if (write_en !== 1'b1 || write_reg !== {a20[3:0], a20} || sof_error !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pre-resync write %0d got we=%b wr=%h err=%b expected 1/%h/0",
                 a, write_en, write_reg, sof_error, {a20[3:0], a20});
      end
    end
    in_sof = 1'b1; in_pixel = 4'hC;
    tick();
    checks++;
    if (write_en !== 1'b1 || write_reg !== 24'hC00000 || sof_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resync beat got we=%b wr=%h err=%b expected 1/c00000/1",
               write_en, write_reg, sof_error);
    end
    for (int a = 1; a < N; a++) begin
      a20 = 20'(a);
      in_sof = 1'b0; in_pixel = a20[3:0];
      tick();
      checks++;
      if (write_en !== 1'b1 || write_reg !== {a20[3:0], a20} || sof_error !== 1'b0 ||
          frame_done !== (a == N - 1)) begin
        errors++;
        $display("[TB] FAIL post-resync write %0d got we=%b wr=%h err=%b done=%b expected 1/%h/0/%b",
                 a, write_en, write_reg, sof_error, frame_done, {a20[3:0], a20}, (a == N - 1));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resync frame end got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_clear;
    logic [19:0] a20;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || write_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear armed got busy=%b rdy=%b we=%b expected 1/0/0", busy, in_ready, write_en);
    end
    for (int a = 0; a < N; a++) begin
      a20 = 20'(a);
      start = (a == 10);
      tick();
      start = 1'b0;
      checks++;
      if (write_en !== 1'b1 || write_reg !== {4'h5, a20} || in_ready !== 1'b0 ||
          frame_done !== (a == N - 1)) begin
        errors++;
        $display("[TB] FAIL clear write %0d got we=%b wr=%h rdy=%b done=%b expected 1/%h/0/%b",
                 a, write_en, write_reg, in_ready, frame_done, {4'h5, a20}, (a == N - 1));
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || write_en !== 1'b0 || write_reg !== {4'h5, 20'd31}) begin
      errors++;
      $display("[TB] FAIL after clear got busy=%b we=%b wr=%h expected 0/0/50001f", busy, write_en, write_reg);
    end
  endtask

  task automatic test_start_and_clear;
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    tick();
    checks++;
    if (write_en !== 1'b1 || write_reg !== 24'h500000 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start+clear got we=%b wr=%h rdy=%b expected 1/500000/0", write_en, write_reg, in_ready);
    end
    repeat (N - 1) tick();
    checks++;
    if (frame_done !== 1'b1 || write_reg !== {4'h5, 20'd31}) begin
      errors++;
      $display("[TB] FAIL start+clear end got done=%b wr=%h expected 1/50001f", frame_done, write_reg);
    end
  endtask

  task automatic test_reset_mid;
    logic [19:0] a20;
    pulse_start();
    for (int a = 0; a < 20; a++) begin
      a20 = 20'(a);
      in_valid = 1'b1; in_sof = (a == 0); in_pixel = a20[3:0];
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (write_en !== 1'b0 || write_reg !== 24'h0 || busy !== 1'b0 || in_ready !== 1'b0 ||
        frame_done !== 1'b0 || sof_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid-frame reset got we=%b wr=%h busy=%b rdy=%b done=%b err=%b expected all 0",
               write_en, write_reg, busy, in_ready, frame_done, sof_error);
    end
    in_valid = 1'b0; in_sof = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    pulse_start();
    for (int a = 0; a < N; a++) begin
      a20 = 20'(a);
      in_valid = 1'b1; in_sof = (a == 0); in_pixel = a20[3:0] ^ 4'h7;
      tick();
      checks++;
      if (write_en !== 1'b1 || write_reg !== {a20[3:0] ^ 4'h7, a20} || frame_done !== (a == N - 1)) begin
        errors++;
        $display("[TB] FAIL post-reset write %0d got we=%b wr=%h done=%b expected 1/%h/%b",
                 a, write_en, write_reg, frame_done, {a20[3:0] ^ 4'h7, a20}, (a == N - 1));
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_sof_resync();
    test_clear();
    test_start_and_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
